// File: rtl/inst_dec_if.sv
// Valid/ready bundle between fetch, the instruction decode stage and its consumers.
// master = fetch + downstream side, slave = decode stage.
interface inst_dec_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic            rd_we;

    modport master (
        output in_valid, inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, pc, rs1, rs2, rd, opcode, funct3, funct7,
               imm, fmt, illegal, rd_we
    );

    modport slave (
        input  in_valid, inst, in_pc, flush, out_ready,
        output in_ready, out_valid, pc, rs1, rs2, rd, opcode, funct3, funct7,
               imm, fmt, illegal, rd_we
    );
endinterface

// File: rtl/inst_dec_stage.sv
// Registered RV32I decode stage: splits fields, classifies the format, builds the
// sign-extended immediate and flags illegal encodings, with optional skid buffer.
module inst_dec_stage #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    inst_dec_if.slave  bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic            rd_we;
    } entry_t;

    entry_t      m_ent, s_ent, d_ent;
    logic        m_valid, s_valid;
    logic        acc;
    logic [31:0] ins;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  dfmt;
    logic [31:0] dimm32;

    assign ins = bus.inst;
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    // Opcode match implies inst[1:0] == 2'b11, so no separate check is needed.
    always_comb begin
        dfmt = FMT_ILL;
        case (ins[6:0])
            7'b0110111, 7'b0010111: dfmt = FMT_U;
            7'b1101111: dfmt = FMT_J;
            7'b1100111: if (f3 == 3'b000) dfmt = FMT_I;
            7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) dfmt = FMT_B;
            7'b0000011: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) dfmt = FMT_I;
            7'b0100011: if (f3 <= 3'b010) dfmt = FMT_S;
            7'b0010011: begin
                case (f3)
                    3'b001:  if (f7 == 7'b0000000) dfmt = FMT_I;
                    3'b101:  if (f7 == 7'b0000000 || f7 == 7'b0100000) dfmt = FMT_I;
                    default: dfmt = FMT_I;
                endcase
            end
            7'b0110011: begin
                if (f7 == 7'b0000000 ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
                    dfmt = FMT_R;
            end
            default: dfmt = FMT_ILL;
        endcase

        dimm32 = '0;
        case (dfmt)
            FMT_I:   dimm32 = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   dimm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   dimm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   dimm32 = {ins[31:12], 12'b0};
            FMT_J:   dimm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: dimm32 = '0;
        endcase

        d_ent         = '0;
        d_ent.pc      = bus.in_pc;
        d_ent.inst    = ins;
        d_ent.imm     = XLEN'($signed(dimm32));
        d_ent.fmt     = dfmt;
        d_ent.illegal = (dfmt == FMT_ILL);
        d_ent.rd_we   = (dfmt == FMT_R || dfmt == FMT_I || dfmt == FMT_U || dfmt == FMT_J)
                        && (ins[11:7] != 5'd0);
    end

    // With SKID the ready only depends on skid occupancy, breaking the out_ready path.
    assign bus.in_ready = SKID ? !s_valid : (!m_valid || bus.out_ready);
    assign acc          = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_ent   <= '0;
            s_ent   <= '0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!m_valid || bus.out_ready) begin
            if (s_valid) begin
                m_ent   <= s_ent;
                m_valid <= 1'b1;
                s_valid <= acc;
                if (acc) s_ent <= d_ent;
            end else begin
                m_valid <= acc;
                if (acc) m_ent <= d_ent;
            end
        end else if (SKID && acc) begin
            s_valid <= 1'b1;
            s_ent   <= d_ent;
        end
    end

    assign bus.out_valid = m_valid;
    assign bus.pc        = m_ent.pc;
    assign bus.rs1       = m_ent.inst[19:15];
    assign bus.rs2       = m_ent.inst[24:20];
    assign bus.rd        = m_ent.inst[11:7];
    assign bus.opcode    = m_ent.inst[6:0];
    assign bus.funct3    = m_ent.inst[14:12];
    assign bus.funct7    = m_ent.inst[31:25];
    assign bus.imm       = m_ent.imm;
    assign bus.fmt       = m_ent.fmt;
    assign bus.illegal   = m_ent.illegal;
    assign bus.rd_we     = m_ent.rd_we;
endmodule

// File: tb/tb_inst_dec_stage.sv
// Bench for inst_dec_stage: vector table through a scoreboard on a SKID=1/XLEN=32
// instance, plus directed skid, flush, reset and XLEN=64/SKID=0 sequences.
module tb_inst_dec_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_dec_if #(.XLEN(32)) bus();
    inst_dec_if #(.XLEN(64)) bus64();

    inst_dec_stage #(.XLEN(32), .SKID(1'b1)) u_dut   (.clk(clk), .rst(rst), .bus(bus));
    inst_dec_stage #(.XLEN(64), .SKID(1'b0)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        rd_we;
        logic        ill;
    } exp_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_out = 0;
    int   cyc = 0;
    exp_t sbq[$];
    int   out_cyc[$];
    exp_t cur;
    exp_t vec[19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] i, input logic [2:0] f,
                                input logic [31:0] im, input logic we, input logic il);
        exp_t e;
        e.inst = i; e.pc = 32'h0; e.fmt = f; e.imm = im; e.rd_we = we; e.ill = il;
        return e;
    endfunction

    function automatic exp_t at_pc(input exp_t e, input logic [31:0] p);
        exp_t r;
        r = e;
        r.pc = p;
        return r;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (rst || bus.flush) begin
            sbq.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                out_cyc.push_back(cyc);
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc=%h rd=%0d, required no output", bus.pc, bus.rd);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("sb_pc inst=%h", e.inst), 64'(bus.pc), 64'(e.pc));
                    chk($sformatf("sb_fmt inst=%h", e.inst), 64'(bus.fmt), 64'(e.fmt));
                    chk($sformatf("sb_imm inst=%h", e.inst), 64'(bus.imm), 64'(e.imm));
                    chk($sformatf("sb_illegal inst=%h", e.inst), 64'(bus.illegal), 64'(e.ill));
                    chk($sformatf("sb_rd_we inst=%h", e.inst), 64'(bus.rd_we), 64'(e.rd_we));
                    chk($sformatf("sb_fields inst=%h", e.inst),
                        64'({bus.rs1, bus.rs2, bus.rd, bus.opcode, bus.funct3, bus.funct7}),
                        64'({e.inst[19:15], e.inst[24:20], e.inst[11:7], e.inst[6:0],
                             e.inst[14:12], e.inst[31:25]}));
                end
            end
            if (bus.in_valid && bus.in_ready) sbq.push_back(cur);
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input exp_t e);
        cur = e;
        bus.inst = e.inst;
        bus.in_pc = e.pc;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: inst=%h never accepted, required accept within 50 cycles", e.inst);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 30 && sbq.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk(nm, 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        vec[0]  = mk(32'hFFF00093, 3'd1, 32'hFFFFFFFF, 1'b1, 1'b0);
        vec[1]  = mk(32'h0020A423, 3'd2, 32'h00000008, 1'b0, 1'b0);
        vec[2]  = mk(32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 1'b0, 1'b0);
        vec[3]  = mk(32'h001000EF, 3'd5, 32'h00000800, 1'b1, 1'b0);
        vec[4]  = mk(32'h123452B7, 3'd4, 32'h12345000, 1'b1, 1'b0);
        vec[5]  = mk(32'h00000000, 3'd7, 32'h0, 1'b0, 1'b1);
        vec[6]  = mk(32'h40001033, 3'd7, 32'h0, 1'b0, 1'b1);
        vec[7]  = mk(32'h00002067, 3'd7, 32'h0, 1'b0, 1'b1);
        vec[8]  = mk(32'h40208033, 3'd0, 32'h0, 1'b0, 1'b0);
        vec[9]  = mk(32'h00208133, 3'd0, 32'h0, 1'b1, 1'b0);
        vec[10] = mk(32'h4011D193, 3'd1, 32'h00000401, 1'b1, 1'b0);
        vec[11] = mk(32'h02009093, 3'd7, 32'h0, 1'b0, 1'b1);
        vec[12] = mk(32'h80000017, 3'd4, 32'h80000000, 1'b0, 1'b0);
        vec[13] = mk(32'h00003003, 3'd7, 32'h0, 1'b0, 1'b1);
        vec[14] = mk(32'hFFE2C203, 3'd1, 32'hFFFFFFFE, 1'b1, 1'b0);
        vec[15] = mk(32'h00002063, 3'd7, 32'h0, 1'b0, 1'b1);
        vec[16] = mk(32'h00003023, 3'd7, 32'h0, 1'b0, 1'b1);
        vec[17] = mk(32'h00008067, 3'd1, 32'h0, 1'b0, 1'b0);
        vec[18] = mk(32'h00000011, 3'd7, 32'h0, 1'b0, 1'b1);

        bus.in_valid = 0; bus.inst = '0; bus.in_pc = '0; bus.flush = 0; bus.out_ready = 0;
        bus64.in_valid = 0; bus64.inst = '0; bus64.in_pc = '0; bus64.flush = 0; bus64.out_ready = 0;

        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'({bus.pc, bus.rd, bus.opcode}), 64'd0);
        chk("rst_imm", 64'(bus.imm), 64'd0);
        chk("rst_flags", 64'({bus.fmt, bus.illegal, bus.rd_we}), 64'd0);
        chk("rst64_out_valid", 64'(bus64.out_valid), 64'd0);
        chk("rst64_imm", bus64.imm, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single instruction, one-cycle latency.
        bus.out_ready = 1'b1;
        send(at_pc(vec[0], 32'h100));
        @(negedge clk);
        chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Table back-to-back with out_ready held high.
        base = out_cyc.size();
        for (int i = 1; i < 19; i++) send(at_pc(vec[i], 32'h104 + 32'(i) * 4));
        drain("table_drain");
        chk("table_count", 64'(out_cyc.size() - base), 64'd18);
        for (int k = 0; k < 3; k++)
            chk($sformatf("b2b_gap_%0d", k), 64'(out_cyc[base + k + 1] - out_cyc[base + k]), 64'd1);

        // Skid: three offered while stalled, two accepted, third held.
        bus.out_ready = 1'b0;
        send(at_pc(vec[9], 32'h200));
        send(at_pc(vec[10], 32'h204));
        cur = at_pc(vec[14], 32'h208);
        bus.inst = cur.inst; bus.in_pc = cur.pc; bus.in_valid = 1'b1;
        @(negedge clk);
        chk("skid_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("skid_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("skid_hold_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("skid_hold_head_pc", 64'(bus.pc), 64'h200);
        @(posedge clk);
        #1;
        base = n_out;
        bus.out_ready = 1'b1;
        send(at_pc(vec[14], 32'h208));
        drain("skid_drain");
        chk("skid_out_count", 64'(n_out - base), 64'd3);

        // Flush with two entries held and the input offered.
        bus.out_ready = 1'b0;
        send(at_pc(vec[1], 32'h300));
        send(at_pc(vec[2], 32'h304));
        cur = at_pc(vec[3], 32'h308);
        bus.inst = cur.inst; bus.in_pc = cur.pc; bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush2_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush2_in_ready", 64'(bus.in_ready), 64'd1);
        base = n_out;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush2_no_output", 64'(n_out - base), 64'd0);

        // Flush with one held entry and an accepted input: both discarded.
        bus.out_ready = 1'b0;
        send(at_pc(vec[4], 32'h400));
        cur = at_pc(vec[12], 32'h404);
        bus.inst = cur.inst; bus.in_pc = cur.pc; bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        chk("flush1_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush1_out_valid", 64'(bus.out_valid), 64'd0);
        base = n_out;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush1_no_output", 64'(n_out - base), 64'd0);
        send(at_pc(vec[3], 32'h408));
        drain("post_flush_drain");

        // Asynchronous reset mid-stream.
        bus.out_ready = 1'b0;
        send(at_pc(vec[5], 32'h500));
        send(at_pc(vec[6], 32'h504));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        base = n_out;
        bus.out_ready = 1'b1;
        send(at_pc(vec[0], 32'h600));
        @(negedge clk);
        chk("rst_recover_latency", 64'(bus.out_valid), 64'd1);
        chk("rst_recover_pc", 64'(bus.pc), 64'h600);
        @(posedge clk);
        #1;
        drain("rst_recover_drain");
        chk("rst_recover_count", 64'(n_out - base), 64'd1);

        // XLEN=64, SKID=0 instance.
        bus64.out_ready = 1'b0;
        bus64.inst = 32'hFFF00093; bus64.in_pc = 64'h1_0000_0100; bus64.in_valid = 1'b1;
        @(negedge clk);
        chk("x64_in_ready_empty", 64'(bus64.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
        @(negedge clk);
        chk("x64_out_valid", 64'(bus64.out_valid), 64'd1);
        chk("x64_addi_imm", bus64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("x64_addi_pc", bus64.pc, 64'h1_0000_0100);
        chk("x64_addi_flags", 64'({bus64.fmt, bus64.illegal, bus64.rd_we}), 64'({3'd1, 1'b0, 1'b1}));
        chk("x64_in_ready_stalled", 64'(bus64.in_ready), 64'd0);
        #1;
        bus64.out_ready = 1'b1;
        bus64.inst = 32'hFE000EE3; bus64.in_pc = 64'h1_0000_0104; bus64.in_valid = 1'b1;
        #1;
        chk("x64_in_ready_comb", 64'(bus64.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus64.inst = 32'h80000017; bus64.in_pc = 64'h1_0000_0108;
        @(negedge clk);
        chk("x64_beq_fmt", 64'(bus64.fmt), 64'd3);
        chk("x64_beq_imm", bus64.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
        @(negedge clk);
        chk("x64_auipc_fmt", 64'(bus64.fmt), 64'd4);
        chk("x64_auipc_imm", bus64.imm, 64'hFFFF_FFFF_8000_0000);
        chk("x64_auipc_rd_we", 64'(bus64.rd_we), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("x64_empty", 64'(bus64.out_valid), 64'd0);

        chk("final_scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_dec_stage.md
Name: inst_dec_stage

Overview:
Registered, handshaked instruction decode stage for the RV32I core. Accepts one fetched instruction plus its PC per valid/ready transfer and splits it into register indices, control fields, a format class and a fully generated, sign-extended immediate for every base format (I/S/B/U/J). It also flags illegal encodings and computes rd write-enable. It sits between fetch and the register file / control unit, and replaces the purely combinational field splitter with a pipeline stage that supports backpressure and flush.

Parameters:
XLEN, 32, datapath width; imm and pc are XLEN bits and imm is sign-extended to XLEN (legal: 32, 64)
SKID, 1, 1 = two-entry output (main register + skid buffer) with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  fetch presents inst/in_pc
in_ready  out  1  stage can accept this cycle
inst  in  32  raw instruction
in_pc  in  XLEN  PC of inst
flush  in  1  synchronous kill of all held entries
out_valid  out  1  decoded entry present
out_ready  in  1  downstream accepts
pc  out  XLEN  PC of the decoded entry
rs1, rs2, rd  out  5 each  inst[19:15], inst[24:20], inst[11:7]
opcode  out  7  inst[6:0]
funct3  out  3  inst[14:12]
funct7  out  7  inst[31:25]
imm  out  XLEN  generated immediate, sign-extended
fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5, ILL=7
illegal  out  1  encoding not in RV32I subset below
rd_we  out  1  instruction writes rd

Behaviour:
- Transfer on a rising edge with in_valid && in_ready (input side) or out_valid && out_ready (output side).
- Latency: accept in cycle N gives out_valid=1 in cycle N+1. Throughput is 1 per cycle when out_ready=1.
- Reset (async assert): out_valid=0, skid empty, all data outputs 0, fmt=0, illegal=0, rd_we=0. in_ready=1 from the first edge after release.
- SKID=0: in_ready = !out_valid || out_ready (combinational).
- SKID=1: in_ready = !skid_valid (registered).
  - Accept while the main register is full and out_ready=0 writes the skid entry.
  - If out_ready=1 and skid_valid, the main register loads the skid entry and the skid is cleared. A simultaneous accept goes to the skid.
  - Order is strictly FIFO.
- Decode is a function of inst only and is registered with the entry.
- imm by format:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R and ILL: 0
  - All formats sign-extend from the top bit to XLEN.
- Legal set (everything else gives fmt=ILL, illegal=1, imm=0, rd_we=0). inst[1:0] must be 11.
  - 0110111 LUI U; 0010111 AUIPC U; 1101111 JAL J
  - 1100111 JALR I, funct3=000
  - 1100011 BRANCH B, funct3 not 010/011
  - 0000011 LOAD I, funct3 in {000,001,010,100,101}
  - 0100011 STORE S, funct3 <= 010
  - 0010011 OP-IMM I; funct3=001 requires funct7=0000000; funct3=101 requires funct7 in {0000000,0100000}
  - 0110011 OP R; funct7=0000000 any funct3, or funct7=0100000 with funct3 in {000,101}
- rd_we = !illegal && fmt in {R,I,U,J} && rd != 0.
- Raw fields (rs1/rs2/rd/opcode/funct3/funct7) are always passed through, even when the encoding is illegal.
- flush=1 at an edge: out_valid and skid_valid go to 0. An input handshake in the same cycle is consumed and discarded. flush wins over every simultaneous event.
- Data outputs hold their last value while out_valid=0; the bench must not check them then.
- Reset mid-transfer drops all entries immediately (async).

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), pc=0x100 -> next cycle: out_valid=1, fmt=I, imm=0xFFFFFFFF, rd=1, rs1=0, rd_we=1, illegal=0, pc=0x100.
- Back-to-back 0x0020A423 (sw x2,8(x1)), 0xFE000EE3 (beq x0,x0,-4), 0x001000EF (jal x1,2048), 0x123452B7 (lui x5,0x12345) with out_ready=1. Required outputs, in order:
  - S, imm=8, rd_we=0
  - B, imm=0xFFFFFFFC, rd_we=0
  - J, imm=0x800, rd_we=1
  - U, imm=0x12345000, rd=5
  - One result per cycle.
- Illegal inputs -> illegal=1, fmt=7, imm=0, rd_we=0:
  - 0x00000000
  - 0x40001033 (funct7=0100000, funct3=001)
  - 0x00002067 (JALR with funct3=010)
- SKID=1, out_ready=0 for 3 cycles with 3 instructions offered -> first two accepted, in_ready=0 after the second, third held by fetch. After out_ready=1 all three emerge in order with no loss or duplication.
- Two entries held (SKID=1) plus flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- rst asserted mid-stream between edges -> out_valid=0 immediately. After release, the first accepted instruction decodes correctly with 1-cycle latency. With XLEN=64, 0xFFF00093 gives imm=0xFFFFFFFFFFFFFFFF.
